softex_streamer_tail_pad: RTL

Load-path counterpart of the store-side strobe generator. Sits between the HCI source streamer and the datapath. Counts accepted beats of a load stream and, on the final beat of a vector whose length is not a multiple of the bus width, replaces the bytes past the vector end with a neutral fill element (default BF16 −inf) so they cannot affect max or exp-sum reductions. It also registers the stream and tags the final beat.

---
 rtl/softex_pkg.sv | 30 +++
 rtl/hwpe_stream_intf_stream.sv | 24 ++
 rtl/softex_stream_pipe_reg.sv | 48 ++++
 rtl/softex_streamer_tail_pad.sv | 110 +++++++++++
 4 files changed

// File: rtl/softex_pkg.sv
// softex shared types and helpers.
// Streamer control view, bus width defaults and tail-length math.
package softex_pkg;

  localparam int unsigned DATA_W = 160;

  localparam logic [15:0] SOFTEX_PAD_NEG_INF = 16'hFF80;

  typedef struct packed {
    logic [31:0] tot_len;
    logic [31:0] d0_len;
    logic [31:0] d0_stride;
  } hci_addressgen_ctrl_t;

  typedef struct packed {
    hci_addressgen_ctrl_t addressgen_ctrl;
  } hci_streamer_ctrl_t;

  // Valid bytes in the final beat; zero when the vector is bus-aligned.
  function automatic logic [31:0] softex_tail_len(
    input logic [31:0] d0_len,
    input logic [31:0] d0_stride,
    input int unsigned lb
  );
    logic [31:0] m;
    m = (32'd1 << lb) - 32'd1;
    return d0_len & (d0_stride - 32'd1) & m;
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready byte-strobed stream bundle.
// Source drives payload, sink drives ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (
    output valid, data, strb,
    input  ready
  );

  modport sink (
    input  valid, data, strb,
    output ready
  );

endinterface

// File: rtl/softex_stream_pipe_reg.sv
// One-entry valid/ready register with a 1-bit sideband.
// Full throughput: accepts a new beat while the old one leaves.
module softex_stream_pipe_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  input  logic         side_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         side_o
);

  logic         valid_q;
  logic [W-1:0] data_q;
  logic         side_q;

  assign ready_o = ~valid_q | ready_i;

  // Load on input handshake, drain on a lone output handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      side_q  <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      side_q  <= 1'b0;
    end else if (valid_i & ready_o) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      side_q  <= side_i;
    end else if (valid_q & ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign side_o  = side_q;

endmodule

// File: rtl/softex_streamer_tail_pad.sv
// Load-path tail padder: fills bytes past the vector end
// with a neutral element and tags the final beat.
module softex_streamer_tail_pad
  import softex_pkg::*;
#(
  parameter int unsigned    DW   = DATA_W,
  parameter int unsigned    EW   = 16,
  parameter logic [EW-1:0]  FILL = SOFTEX_PAD_NEG_INF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  hci_streamer_ctrl_t    stream_ctrl_i,
  hwpe_stream_intf_stream.sink   stream_i,
  hwpe_stream_intf_stream.source stream_o,
  output logic                  last_o,
  output logic                  done_o
);

  localparam int unsigned ADW = DW - 32;
  localparam int unsigned NB  = ADW / 8;
  localparam int unsigned NS  = DW / 8;
  localparam int unsigned LB  = $clog2(NB);
  localparam int unsigned EB  = EW / 8;

  logic [31:0]   lftovr;
  logic          is_lftovr;
  logic          is_final;
  logic          pad;
  logic          in_ready;
  logic          in_hs;
  logic [31:0]   cnt_q;
  logic [31:0]   cnt_d;
  logic [DW-1:0] pad_data;
  logic          out_valid;
  logic          out_last;
  logic [DW-1:0] out_data;

  assign lftovr = softex_tail_len(
    stream_ctrl_i.addressgen_ctrl.d0_len,
    stream_ctrl_i.addressgen_ctrl.d0_stride,
    LB
  );
  assign is_lftovr = |lftovr;

  assign is_final = cnt_q ==
    (stream_ctrl_i.addressgen_ctrl.tot_len - 32'd1);
  assign pad   = is_final & is_lftovr;
  assign in_hs = stream_i.valid & in_ready;

  assign stream_i.ready = in_ready;

  // Beat index within the job; wraps so jobs chain without clear.
  always_comb begin
    cnt_d = cnt_q;
    if (in_hs) begin
      cnt_d = is_final ? 32'd0 : cnt_q + 32'd1;
    end
  end

  // Counter state, cleared by reset or clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Replace tail bytes with the fill element; top 32 bits zero.
  always_comb begin
    pad_data = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (pad && (32'(i) >= lftovr)) begin
        pad_data[8*i +: 8] = FILL[8*(i%EB) +: 8];
      end else begin
        pad_data[8*i +: 8] = stream_i.data[8*i +: 8];
      end
    end
  end

  softex_stream_pipe_reg #(
    .W (DW)
  ) u_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .valid_i (stream_i.valid),
    .ready_o (in_ready),
    .data_i  (pad_data),
    .side_i  (is_final),
    .valid_o (out_valid),
    .ready_i (stream_o.ready),
    .data_o  (out_data),
    .side_o  (out_last)
  );

  assign stream_o.valid = out_valid;
  assign stream_o.data  = out_data;
  assign stream_o.strb  = {{(NS-NB){1'b0}}, {NB{1'b1}}};

  assign last_o = out_valid & out_last;
  assign done_o = out_valid & stream_o.ready & out_last;

  logic unused_ok;
  assign unused_ok = ^{stream_i.strb, stream_i.data[DW-1:ADW]};

endmodule
